dense_feeder: RTL and testbench

//  Sequencer that drives the dense-layer MAC. It reads feature bytes from the feature buffer and

---
 rtl/cnn_dense_pkg.sv | 17 +
 rtl/dense_feed_ctr.sv | 36 +++
 rtl/dense_feeder.sv | 141 ++++++++++++++
 tb/tb_dense_feeder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_dense_pkg.sv
// Shared defaults and the feeder FSM state encoding for the dense-layer datapath.
package cnn_dense_pkg;

   localparam int DEF_IN_LEN  = 1152;
   localparam int DEF_OUT_LEN = 10;
   localparam int DEF_DW      = 8;
   localparam int DEF_ACC_W   = 32;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_DRAIN   = 3'd2,
      S_PRESENT = 3'd3,
      S_FINISH  = 3'd4
   } feed_state_t;

endpackage

// File: rtl/dense_feed_ctr.sv
// Term index k and free-running weight pointer wp; wp walks n*IN_LEN+k without a multiplier.
module dense_feed_ctr #(
   parameter int IN_LEN  = 1152,
   parameter int OUT_LEN = 10,
   parameter int AW      = 11,
   parameter int WAW     = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           inc,
   output logic [AW-1:0]  k,
   output logic [WAW-1:0] wp,
   output logic           k_last
);

   localparam logic [AW-1:0]  K_LAST  = AW'(IN_LEN - 1);
   localparam logic [WAW-1:0] WP_LAST = WAW'(IN_LEN * OUT_LEN - 1);

   assign k_last = (k == K_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k  <= '0;
         wp <= '0;
      end else if (clr) begin
         k  <= '0;
         wp <= '0;
      end else if (inc) begin
         k  <= k_last ? '0 : k + AW'(1);
         // wrap keeps wp inside the ROM even if a pass ever runs past the last neuron
         wp <= (wp == WP_LAST) ? '0 : wp + WAW'(1);
      end
   end

endmodule

// File: rtl/dense_feeder.sv
// Dense-layer MAC feeder: streams feature/weight byte pairs per neuron, then presents
// the captured accumulator on a valid/ready port.
//
//  state     | meaning
//  S_IDLE    | waiting for start
//  S_ISSUE   | issuing feature/weight addresses, one term per cycle
//  S_DRAIN   | waiting for the last term to reach the MAC sum
//  S_PRESENT | holding out_data/out_idx until out_ready
//  S_FINISH  | pulsing done, returning to idle
module dense_feeder
   import cnn_dense_pkg::*;
#(
   parameter int IN_LEN  = DEF_IN_LEN,
   parameter int OUT_LEN = DEF_OUT_LEN,
   parameter int DW      = DEF_DW,
   parameter int AW      = 11,
   parameter int WAW     = 15,
   parameter int OW      = 4,
   parameter int ACC_W   = DEF_ACC_W,
   parameter int MAC_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    feat_addr,
   input  logic [DW-1:0]    feat_rdata,
   output logic [WAW-1:0]   wgt_addr,
   input  logic [DW-1:0]    wgt_rdata,
   output logic             mac_en,
   output logic             mac_clr,
   output logic [DW-1:0]    mac_data,
   output logic [DW-1:0]    mac_weight,
   input  logic [ACC_W-1:0] mac_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OW-1:0]    out_idx,
   output logic [ACC_W-1:0] out_data
);

   localparam int DCW = $clog2(MAC_LAT + 1) + 1;
   localparam logic [OW-1:0] N_LAST = OW'(OUT_LEN - 1);

   feed_state_t    state;
   logic [OW-1:0]  n;
   logic [DCW-1:0] drain_cnt;
   logic [AW-1:0]  k;
   logic [WAW-1:0] wp;
   logic           k_last;
   logic           ctr_clr;
   logic           ctr_inc;

   assign ctr_clr = (state == S_FINISH) || ((state == S_IDLE) && start);
   assign ctr_inc = (state == S_ISSUE);

   dense_feed_ctr #(
      .IN_LEN  (IN_LEN),
      .OUT_LEN (OUT_LEN),
      .AW      (AW),
      .WAW     (WAW)
   ) u_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (ctr_clr),
      .inc    (ctr_inc),
      .k      (k),
      .wp     (wp),
      .k_last (k_last)
   );

   assign feat_addr = k;
   assign wgt_addr  = wp;

   // the ROM/buffer read stage is the term pipeline; gating keeps the bus quiet between terms
   assign mac_data   = mac_en ? feat_rdata : '0;
   assign mac_weight = mac_en ? wgt_rdata  : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         mac_en    <= 1'b0;
         mac_clr   <= 1'b0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_data  <= '0;
         n         <= '0;
         drain_cnt <= '0;
      end else begin
         done    <= 1'b0;
         mac_en  <= (state == S_ISSUE);
         mac_clr <= (state == S_ISSUE) && (k == '0);
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_ISSUE;
                  busy  <= 1'b1;
                  n     <= '0;
               end
            end
            S_ISSUE: begin
               if (k_last) begin
                  state     <= S_DRAIN;
                  drain_cnt <= DCW'(MAC_LAT);
               end
            end
            S_DRAIN: begin
               if (drain_cnt == '0) begin
                  out_data  <= mac_acc;
                  out_idx   <= n;
                  out_valid <= 1'b1;
                  state     <= S_PRESENT;
               end else begin
                  drain_cnt <= drain_cnt - DCW'(1);
               end
            end
            S_PRESENT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (n == N_LAST) begin
                     state <= S_FINISH;
                  end else begin
                     n     <= n + OW'(1);
                     state <= S_ISSUE;
                  end
               end
            end
            S_FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               n     <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dense_feeder.sv
// Bench for dense_feeder: small instance (4x2) for protocol/backpressure/reset cases,
// default-size instance for the full 1152x10 pass.
module tb_dense_feeder;
   import cnn_dense_pkg::*;

   localparam int IN_LEN  = 4;
   localparam int OUT_LEN = 2;
   localparam int MAC_LAT = 1;
   localparam int DW      = 8;
   localparam int AW      = 11;
   localparam int WAW     = 15;
   localparam int OW      = 4;
   localparam int ACC_W   = 32;
   localparam int BIG_IN  = DEF_IN_LEN;
   localparam int BIG_OUT = DEF_OUT_LEN;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- small instance ----------------
   logic             start, busy, done, mac_en, mac_clr, out_valid, out_ready;
   logic [AW-1:0]    feat_addr;
   logic [WAW-1:0]   wgt_addr;
   logic [DW-1:0]    feat_rdata, wgt_rdata, mac_data, mac_weight;
   logic [ACC_W-1:0] mac_acc, out_data;
   logic [OW-1:0]    out_idx;

   logic [DW-1:0] feat_mem [IN_LEN];
   logic [DW-1:0] wgt_mem  [IN_LEN*OUT_LEN];

   dense_feeder #(
      .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .DW(DW), .AW(AW), .WAW(WAW),
      .OW(OW), .ACC_W(ACC_W), .MAC_LAT(MAC_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .feat_addr(feat_addr), .feat_rdata(feat_rdata),
      .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
      .mac_en(mac_en), .mac_clr(mac_clr), .mac_data(mac_data), .mac_weight(mac_weight),
      .mac_acc(mac_acc), .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_data(out_data)
   );

   always @(posedge clk) begin
      feat_rdata <= (int'(feat_addr) < IN_LEN) ? feat_mem[int'(feat_addr)] : '0;
      wgt_rdata  <= (int'(wgt_addr) < IN_LEN*OUT_LEN) ? wgt_mem[int'(wgt_addr)] : '0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mac_acc <= '0;
      else if (mac_en) mac_acc <= (mac_clr ? 32'd0 : mac_acc) + 32'(mac_data) * 32'(mac_weight);
   end

   // ---------------- default-size instance ----------------
   logic             b_start, b_busy, b_done, b_mac_en, b_mac_clr, b_out_valid, b_out_ready;
   logic [AW-1:0]    b_feat_addr;
   logic [WAW-1:0]   b_wgt_addr;
   logic [DW-1:0]    b_feat_rdata, b_wgt_rdata, b_mac_data, b_mac_weight;
   logic [ACC_W-1:0] b_mac_acc, b_out_data;
   logic [OW-1:0]    b_out_idx;

   logic [DW-1:0] b_feat_mem [BIG_IN];
   logic [DW-1:0] b_wgt_mem  [BIG_IN*BIG_OUT];

   dense_feeder dut_big (
      .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
      .feat_addr(b_feat_addr), .feat_rdata(b_feat_rdata),
      .wgt_addr(b_wgt_addr), .wgt_rdata(b_wgt_rdata),
      .mac_en(b_mac_en), .mac_clr(b_mac_clr), .mac_data(b_mac_data), .mac_weight(b_mac_weight),
      .mac_acc(b_mac_acc), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_idx(b_out_idx), .out_data(b_out_data)
   );

   always @(posedge clk) begin
      b_feat_rdata <= (int'(b_feat_addr) < BIG_IN) ? b_feat_mem[int'(b_feat_addr)] : '0;
      b_wgt_rdata  <= (int'(b_wgt_addr) < BIG_IN*BIG_OUT) ? b_wgt_mem[int'(b_wgt_addr)] : '0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) b_mac_acc <= '0;
      else if (b_mac_en) b_mac_acc <= (b_mac_clr ? 32'd0 : b_mac_acc) + 32'(b_mac_data) * 32'(b_mac_weight);
   end

   // ---------------- monitors (sample on negedge) ----------------
   int          done_cnt = 0, run_len = 0, en_viol = 0, hold_viol = 0, rst_viol = 0, valid_cyc0 = 0;
   logic [31:0] fa_q[$], wa_q[$], data_q[$], idx_q[$], run_q[$];
   bit          clr_q[$];
   logic [AW-1:0]    prev_fa = '0;
   logic [WAW-1:0]   prev_wa = '0;
   logic             prev_valid = 1'b0, prev_hs = 1'b0;
   logic [ACC_W-1:0] prev_data = '0;
   logic [OW-1:0]    prev_idx = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         if (busy || done || mac_en || mac_clr || out_valid || feat_addr != 0 || wgt_addr != 0 ||
             mac_data != 0 || mac_weight != 0 || out_idx != 0 || out_data != 0)
            rst_viol++;
         prev_valid = 1'b0;
         run_len    = 0;
      end else begin
         if (mac_en) begin
            fa_q.push_back(32'(prev_fa));
            wa_q.push_back(32'(prev_wa));
            clr_q.push_back(mac_clr);
            run_len++;
            if (out_valid) en_viol++;
         end else if (run_len > 0) begin
            run_q.push_back(32'(run_len));
            run_len = 0;
         end
         if (prev_valid && !prev_hs && (!out_valid || out_data != prev_data || out_idx != prev_idx))
            hold_viol++;
         if (out_valid && out_idx == 0) valid_cyc0++;
         if (out_valid && out_ready) begin
            data_q.push_back(out_data);
            idx_q.push_back(32'(out_idx));
         end
         if (done) done_cnt++;
         prev_valid = out_valid;
         prev_hs    = out_valid && out_ready;
         prev_data  = out_data;
         prev_idx   = out_idx;
      end
      prev_fa = feat_addr;
      prev_wa = wgt_addr;
   end

   int          b_done_cnt = 0;
   logic [31:0] b_data_q[$], b_idx_q[$];
   always @(negedge clk) begin
      if (rst_n) begin
         if (b_out_valid && b_out_ready) begin
            b_data_q.push_back(b_out_data);
            b_idx_q.push_back(32'(b_out_idx));
         end
         if (b_done) b_done_cnt++;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: neuron n is the dot product of the feature vector with weight row n.
   function automatic logic [31:0] model_out(input int n);
      logic [31:0] s = 0;
      for (int j = 0; j < IN_LEN; j++)
         s += 32'(feat_mem[j]) * 32'(wgt_mem[n*IN_LEN + j]);
      return s;
   endfunction

   task automatic run_pass(input string nm, input int bp, input bit restart);
      int d0 = done_cnt, o0 = data_q.size(), t0 = fa_q.size(), r0 = run_q.size();
      int e0 = en_viol, h0 = hold_viol;
      int held = 0, cyc = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      if (restart) begin
         tick();
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      while (done_cnt == d0 && cyc < 2000) begin
         if (bp > 0 && out_valid && held < bp) begin
            out_ready = 1'b0;
            held++;
         end else begin
            out_ready = 1'b1;
         end
         tick();
         cyc++;
      end
      out_ready = 1'b1;
      repeat (20) tick();
      chk({nm, ":done_cnt"}, 32'(done_cnt - d0), 1);
      chk({nm, ":n_out"}, 32'(data_q.size() - o0), OUT_LEN);
      for (int i = 0; i < OUT_LEN; i++) begin
         if (o0 + i < data_q.size()) begin
            chk({nm, ":out_idx"}, idx_q[o0+i], 32'(i));
            chk({nm, ":out_data"}, data_q[o0+i], model_out(i));
         end
      end
      chk({nm, ":n_terms"}, 32'(fa_q.size() - t0), IN_LEN*OUT_LEN);
      for (int j = 0; j < IN_LEN*OUT_LEN && t0 + j < fa_q.size(); j++) begin
         chk({nm, ":feat_addr"}, fa_q[t0+j], 32'(j % IN_LEN));
         chk({nm, ":wgt_addr"}, wa_q[t0+j], 32'(j));
         chk({nm, ":mac_clr"}, 32'(clr_q[t0+j]), 32'(j % IN_LEN == 0));
      end
      chk({nm, ":n_runs"}, 32'(run_q.size() - r0), OUT_LEN);
      for (int r = r0; r < run_q.size(); r++) chk({nm, ":run_len"}, run_q[r], IN_LEN);
      chk({nm, ":en_while_valid"}, 32'(en_viol - e0), 0);
      chk({nm, ":hold"}, 32'(hold_viol - h0), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int v0, t0, d0, cyc;
      rst_n = 1'b0;
      start = 1'b0;
      out_ready = 1'b1;
      b_start = 1'b0;
      b_out_ready = 1'b1;
      for (int j = 0; j < IN_LEN; j++) feat_mem[j] = DW'(j + 1);
      for (int j = 0; j < IN_LEN*OUT_LEN; j++) wgt_mem[j] = (j < IN_LEN) ? 8'd1 : 8'd2;
      for (int j = 0; j < BIG_IN; j++) b_feat_mem[j] = 8'hFF;
      for (int j = 0; j < BIG_IN*BIG_OUT; j++) b_wgt_mem[j] = 8'd1;

      repeat (3) tick();
      chk("rst:busy", 32'(busy), 0);
      chk("rst:done", 32'(done), 0);
      chk("rst:mac_en", 32'(mac_en), 0);
      chk("rst:out_valid", 32'(out_valid), 0);
      chk("rst:feat_addr", 32'(feat_addr), 0);
      chk("rst:wgt_addr", 32'(wgt_addr), 0);
      chk("rst:out_data", out_data, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // fixed vectors: expect 10 and 20, addresses 0..3 twice, wgt 0..7
      chk("t1:model0", model_out(0), 10);
      chk("t1:model1", model_out(1), 20);
      run_pass("t1", 0, 1'b0);

      v0 = valid_cyc0;
      run_pass("t3_bp", 5, 1'b0);
      chk("t3:valid_cycles_idx0", 32'(valid_cyc0 - v0), 6);

      run_pass("t4_restart", 0, 1'b1);

      // reset while draining the first neuron
      t0 = fa_q.size();
      d0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (fa_q.size() < t0 + IN_LEN && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("t5:reach_drain", 32'(fa_q.size() >= t0 + IN_LEN), 1);
      rst_n = 1'b0;
      repeat (3) tick();
      chk("t5:rst_busy", 32'(busy), 0);
      chk("t5:rst_out_valid", 32'(out_valid), 0);
      rst_n = 1'b1;
      repeat (5) tick();
      chk("t5:no_done", 32'(done_cnt - d0), 0);
      chk("t5:busy_after", 32'(busy), 0);
      run_pass("t5_after", 0, 1'b0);
      chk("rst:outputs_zero", 32'(rst_viol), 0);

      // randomized vectors and backpressure
      for (int r = 0; r < 6; r++) begin
         for (int j = 0; j < IN_LEN; j++) feat_mem[j] = DW'($urandom_range(0, 255));
         for (int j = 0; j < IN_LEN*OUT_LEN; j++) wgt_mem[j] = DW'($urandom_range(0, 255));
         run_pass("rnd", int'($urandom_range(0, 4)), 1'b0);
      end

      // default size: 1152 terms of 0xFF*1 per neuron
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      cyc = 0;
      while (b_done_cnt == 0 && cyc < 14000) begin
         tick();
         cyc++;
      end
      repeat (5) tick();
      chk("t6:done_cnt", 32'(b_done_cnt), 1);
      chk("t6:n_out", 32'(b_data_q.size()), BIG_OUT);
      for (int i = 0; i < BIG_OUT && i < b_data_q.size(); i++) begin
         chk("t6:out_idx", b_idx_q[i], 32'(i));
         chk("t6:out_data", b_data_q[i], 32'(BIG_IN * 255));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
